gray_step_arbiter: RTL and testbench
====================================

Name: gray_step_arbiter

Overview:
- Round-robin scheduler that shares one 3-bit gray-code counter among NREQ requesters.
- Each requester asks for a burst of N count steps. The arbiter grants one requester at a time and drives the counter's enable for exactly N cycles.
- It watches the counter's overflow output during the burst and reports the wrap count on completion.
- Sits between client logic and the counter's En/Overflow pins.

Parameters:
- NREQ, 3, number of requesters (2..8).
- LEN_W, 4, width of burst length and wrap count fields.

Ports:
- Clk  input  1  clock; all logic is on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request level.
- req_len  input  NREQ*LEN_W  flattened burst lengths; requester i uses bits [i*LEN_W +: LEN_W].
- hold  input  1  stall: while high, cnt_en is forced low and the burst does not progress.
- ovf_in  input  1  counter Overflow output.
- cnt_en  output  1  counter En.
- gnt  output  NREQ  one-hot grant, high for the whole burst.
- busy  output  1  high in BURST or DONE.
- done  output  1  one-cycle completion pulse.
- done_id  output  $clog2(NREQ)  index of the completed requester; valid with done.
- wrap_cnt  output  LEN_W  overflow rising edges seen in the burst; valid with done.

Behaviour:
- Reset (synchronous, active-high) sets:
  - state to IDLE and the round-robin pointer to 0;
  - cnt_en, gnt, busy, done to 0;
  - done_id and wrap_cnt to 0;
  - the internal remaining-step and wrap counters to 0, and the ovf_in history register to 0.
- A Reset that arrives mid-burst aborts the burst immediately. No done pulse is produced.
- FSM states: IDLE, BURST, DONE.
- IDLE:
  - If any req bit is set, pick the first set bit at or after the pointer, wrapping modulo NREQ.
  - Latch that requester's req_len into the remaining-step counter, record the winner index, and clear the wrap counter.
  - len!=0: go to BURST. len==0: go straight to DONE with wrap_cnt=0 and gnt never asserted.
  - req is sampled only in IDLE.
- BURST:
  - gnt[winner]=1 and busy=1.
  - cnt_en = ~hold.
  - Each cycle with cnt_en=1 decrements the remaining-step counter.
  - When the counter goes 1->0, the next state is DONE.
  - Total cnt_en high cycles equal len exactly; hold cycles extend the burst.
  - Dropping req mid-burst is ignored; the burst completes.
- Wrap counting:
  - A rising edge of ovf_in (registered previous value 0, current 1) during BURST, or in the DONE cycle, increments the wrap counter.
  - The counter saturates at 2^LEN_W-1.
- DONE:
  - gnt=0, cnt_en=0, busy=1 for one cycle.
  - done=1, done_id=winner, wrap_cnt=final count.
  - Pointer becomes (winner+1) mod NREQ.
  - Next state is IDLE.
- Latency: a request seen in IDLE at cycle t produces gnt from t+1 to t+len. done is at t+len+1 with no hold. Minimum grant-to-grant spacing is len+2 cycles.
- done_id and wrap_cnt hold their values until the next done pulse.
- hold has no effect in IDLE or DONE.

Optional Feature:
- Macro: GRAY_STEP_ARBITER_WRAP_STOP_EN.
- Defined:
  - A detected ovf_in rising edge in BURST terminates the burst. The next state is DONE regardless of remaining steps.
  - wrap_cnt reports 1.
  - The remaining steps are discarded.
- Undefined: overflow is counted only and never shortens a burst.

Decomposition:
- Shared package gray_pkg holds:
  - the state encoding constants ST_IDLE=2'd0, ST_BURST=2'd1, ST_DONE=2'd2;
  - the default widths GRAY_W=3 and LEN_W=4.
- One natural sub-module is rr_pick: a combinational round-robin priority selector (req, pointer -> winner index, valid), reusable elsewhere.
- The FSM, counters and edge detect stay in the top module.

Test Plan:
- Single request:
  - Stimulus: req=3'b001, len0=5, hold=0.
  - Response: gnt=001 for cycles 1-5, cnt_en high 5 cycles, done at cycle 6 with done_id=0 and wrap_cnt=0.
- Round robin:
  - Stimulus: req=3'b111 held, all lengths=2.
  - Response: grants in order 0,1,2,0, each done 4 cycles apart, done_id sequence 0,1,2,0.
- Hold stall:
  - Stimulus: len=4, hold high for 3 cycles mid-burst.
  - Response: cnt_en high exactly 4 cycles, gnt high 7 cycles, done one cycle after the last enable.
- Zero length:
  - Stimulus: req=3'b010, len1=0.
  - Response: no gnt and no cnt_en; done the next cycle with done_id=1, wrap_cnt=0; pointer moves to 2.
- Wrap counting:
  - Stimulus: len=15, ovf_in pulsed at burst steps 8 and 15.
  - Response: wrap_cnt=2. With GRAY_STEP_ARBITER_WRAP_STOP_EN: burst ends after step 8, done with wrap_cnt=1.
- Reset mid-burst:
  - Stimulus: Reset asserted at burst step 3 of 6.
  - Response: next cycle gnt=0, cnt_en=0, busy=0, no done; pointer=0; a new req=3'b100 is then granted normally.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the gray-code counter step arbiter: FSM encoding and default widths.
package gray_pkg;

  localparam int GRAY_W = 3;
  localparam int LEN_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/gray_step_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or after ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 3,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int c;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    c     = 0;
    for (int i = 0; i < NREQ; i++) begin
      c = (int'(ptr) + i) % NREQ;
      if (!valid && req[c]) begin
        valid = 1'b1;
        idx   = c[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/gray_step_arbiter.sv
// Round-robin owner of a shared gray counter: grants bursts of N enable steps and counts overflow wraps.
// Optional: GRAY_STEP_ARBITER_WRAP_STOP_EN ends a burst on the first overflow edge.
module gray_step_arbiter #(
  parameter int NREQ  = 3,
  parameter int LEN_W = gray_pkg::LEN_W,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic                  hold,
  input  logic                  ovf_in,
  output logic                  cnt_en,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_W-1:0]      done_id,
  output logic [LEN_W-1:0]      wrap_cnt,
  output logic [1:0]            dbg_state
);
  import gray_pkg::*;

  state_t             state;
  logic [IDX_W-1:0]   ptr, winner, done_id_q, pick_idx;
  logic [LEN_W-1:0]   remain, wrap_q, wrap_hold, wrap_final, pick_len;
  logic               ovf_prev, rise, pick_valid;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign pick_len   = req_len[int'(pick_idx)*LEN_W +: LEN_W];
  assign rise       = ovf_in & ~ovf_prev;
  // Saturating count; includes an edge arriving in the current cycle so DONE can report it.
  assign wrap_final = (rise && (wrap_q != '1)) ? wrap_q + 1'b1 : wrap_q;

  assign cnt_en    = (state == ST_BURST) && !hold;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign done_id   = done ? winner : done_id_q;
  assign wrap_cnt  = done ? wrap_final : wrap_hold;
  assign dbg_state = state;

  always_comb begin
    gnt = '0;
    if (state == ST_BURST) gnt[winner] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      winner    <= '0;
      remain    <= '0;
      wrap_q    <= '0;
      wrap_hold <= '0;
      done_id_q <= '0;
      ovf_prev  <= 1'b0;
    end else begin
      ovf_prev <= ovf_in;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            winner <= pick_idx;
            remain <= pick_len;
            wrap_q <= '0;
            state  <= (pick_len != '0) ? ST_BURST : ST_DONE;
          end
        end
        ST_BURST: begin
          wrap_q <= wrap_final;
          if (cnt_en) remain <= remain - 1'b1;
          if (cnt_en && (remain == LEN_W'(1))) state <= ST_DONE;
`ifdef GRAY_STEP_ARBITER_WRAP_STOP_EN
          if (rise) state <= ST_DONE;
`endif
        end
        ST_DONE: begin
          done_id_q <= winner;
          wrap_hold <= wrap_final;
          ptr       <= (winner == IDX_W'(NREQ-1)) ? '0 : winner + 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_step_arbiter.sv
// Directed vector bench for gray_step_arbiter (NREQ=3, LEN_W=4).
module tb_gray_step_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [2:0]  req;
  logic [11:0] req_len;
  logic        hold;
  logic        ovf_in;
  logic        cnt_en;
  logic [2:0]  gnt;
  logic        busy;
  logic        done;
  logic [1:0]  done_id;
  logic [3:0]  wrap_cnt;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_bad = 0;

  gray_step_arbiter #(.NREQ(3), .LEN_W(4)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req       (req),
    .req_len   (req_len),
    .hold      (hold),
    .ovf_in    (ovf_in),
    .cnt_en    (cnt_en),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .wrap_cnt  (wrap_cnt),
    .dbg_state (dbg_state)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic [2:0]  rq;
    logic [11:0] ln;
    logic        h;
    logic        o;
    logic        e;
    logic [2:0]  g;
    logic        b;
    logic        d;
    logic [1:0]  id;
    logic [3:0]  w;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [2:0] rq, logic [11:0] ln, logic h, logic o,
                              logic e, logic [2:0] g, logic b, logic d, logic [1:0] id, logic [3:0] w);
    vec_t v;
    v.rst = rst; v.rq = rq; v.ln = ln; v.h = h; v.o = o;
    v.e = e; v.g = g; v.b = b; v.d = d; v.id = id; v.w = w;
    return v;
  endfunction

  // Inputs are driven on the falling edge and outputs checked 1 ns later.
  task automatic apply(input vec_t v, input string tag);
    @(negedge Clk);
    Reset = v.rst; req = v.rq; req_len = v.ln; hold = v.h; ovf_in = v.o;
    #1;
    n_vec++;
    if (cnt_en !== v.e) begin n_bad++; $display("FAIL %s cnt_en got %b exp %b", tag, cnt_en, v.e); end
    if (gnt !== v.g) begin n_bad++; $display("FAIL %s gnt got %b exp %b", tag, gnt, v.g); end
    if (busy !== v.b) begin n_bad++; $display("FAIL %s busy got %b exp %b", tag, busy, v.b); end
    if (done !== v.d) begin n_bad++; $display("FAIL %s done got %b exp %b", tag, done, v.d); end
    if (done_id !== v.id) begin n_bad++; $display("FAIL %s done_id got %0d exp %0d", tag, done_id, v.id); end
    if (wrap_cnt !== v.w) begin n_bad++; $display("FAIL %s wrap_cnt got %0d exp %0d", tag, wrap_cnt, v.w); end
  endtask

  initial begin
    // Round robin: all three requesting, length 2 each; starts from pointer 0.
    vecs.push_back(mk(0, 3'b111, 12'h222, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b111, 12'h222, 0, 0, 1, 3'b001, 1, 0, 0, 0));
    vecs.push_back(mk(0, 3'b111, 12'h222, 0, 0, 1, 3'b001, 1, 0, 0, 0));
    vecs.push_back(mk(0, 3'b111, 12'h222, 0, 0, 0, 3'b000, 1, 1, 0, 0));
    vecs.push_back(mk(0, 3'b111, 12'h222, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b111, 12'h222, 0, 0, 1, 3'b010, 1, 0, 0, 0));
    vecs.push_back(mk(0, 3'b111, 12'h222, 0, 0, 1, 3'b010, 1, 0, 0, 0));
    vecs.push_back(mk(0, 3'b111, 12'h222, 0, 0, 0, 3'b000, 1, 1, 1, 0));
    vecs.push_back(mk(0, 3'b111, 12'h222, 0, 0, 0, 3'b000, 0, 0, 1, 0));
    vecs.push_back(mk(0, 3'b111, 12'h222, 0, 0, 1, 3'b100, 1, 0, 1, 0));
    vecs.push_back(mk(0, 3'b111, 12'h222, 0, 0, 1, 3'b100, 1, 0, 1, 0));
    vecs.push_back(mk(0, 3'b111, 12'h222, 0, 0, 0, 3'b000, 1, 1, 2, 0));
    vecs.push_back(mk(0, 3'b111, 12'h222, 0, 0, 0, 3'b000, 0, 0, 2, 0));
    vecs.push_back(mk(0, 3'b000, 12'h222, 0, 0, 1, 3'b001, 1, 0, 2, 0));
    vecs.push_back(mk(0, 3'b000, 12'h222, 0, 0, 1, 3'b001, 1, 0, 2, 0));
    vecs.push_back(mk(0, 3'b000, 12'h222, 0, 0, 0, 3'b000, 1, 1, 0, 0));
    vecs.push_back(mk(0, 3'b000, 12'h222, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    // Single request, length 5; req dropped during the burst (pointer is 1, wraps to 0).
    vecs.push_back(mk(0, 3'b001, 12'h005, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 3'b000, 12'h005, 0, 0, 1, 3'b001, 1, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 12'h005, 0, 0, 0, 3'b000, 1, 1, 0, 0));
    vecs.push_back(mk(0, 3'b000, 12'h005, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    // Zero length on requester 1, then req=011 must pick 0 because the pointer moved to 2.
    vecs.push_back(mk(0, 3'b010, 12'h001, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 12'h001, 0, 0, 0, 3'b000, 1, 1, 1, 0));
    vecs.push_back(mk(0, 3'b011, 12'h001, 0, 0, 0, 3'b000, 0, 0, 1, 0));
    vecs.push_back(mk(0, 3'b000, 12'h001, 0, 0, 1, 3'b001, 1, 0, 1, 0));
    vecs.push_back(mk(0, 3'b000, 12'h001, 0, 0, 0, 3'b000, 1, 1, 0, 0));
    vecs.push_back(mk(0, 3'b000, 12'h001, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    // Hold stall: length 4 on requester 1, hold high in IDLE, 3 mid-burst cycles and DONE.
    vecs.push_back(mk(0, 3'b010, 12'h040, 1, 0, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 12'h040, 0, 0, 1, 3'b010, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 3'b000, 12'h040, 1, 0, 0, 3'b010, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 3'b000, 12'h040, 0, 0, 1, 3'b010, 1, 0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 12'h040, 1, 0, 0, 3'b000, 1, 1, 1, 0));
    vecs.push_back(mk(0, 3'b000, 12'h040, 0, 0, 0, 3'b000, 0, 0, 1, 0));
  end

  initial begin
    Reset = 1'b1; req = '0; req_len = '0; hold = 1'b0; ovf_in = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    #1;
    n_vec++;
    if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d exp 0", dbg_state); end

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Wrap counting: requester 2, length 15, overflow pulses at steps 8 and 15.
    apply(mk(0, 3'b100, 12'hF00, 0, 0, 0, 3'b000, 0, 0, 1, 0), "wrap_idle");
`ifdef GRAY_STEP_ARBITER_WRAP_STOP_EN
    for (int s = 1; s <= 8; s++)
      apply(mk(0, 3'b000, 12'hF00, 0, (s == 8), 1, 3'b100, 1, 0, 1, 0), $sformatf("wrap_step%0d", s));
    apply(mk(0, 3'b000, 12'hF00, 0, 0, 0, 3'b000, 1, 1, 2, 1), "wrap_done");
    apply(mk(0, 3'b000, 12'hF00, 0, 0, 0, 3'b000, 0, 0, 2, 1), "wrap_hold");
`else
    for (int s = 1; s <= 15; s++)
      apply(mk(0, 3'b000, 12'hF00, 0, (s == 8 || s == 15), 1, 3'b100, 1, 0, 1, 0),
            $sformatf("wrap_step%0d", s));
    // Overflow stays high into DONE: a level, not a new edge.
    apply(mk(0, 3'b000, 12'hF00, 0, 1, 0, 3'b000, 1, 1, 2, 2), "wrap_done");
    apply(mk(0, 3'b000, 12'hF00, 0, 0, 0, 3'b000, 0, 0, 2, 2), "wrap_hold");
`endif
    // Overflow edge landing in the DONE cycle is still counted.
    begin
      logic [3:0] wp;
`ifdef GRAY_STEP_ARBITER_WRAP_STOP_EN
      wp = 4'd1;
`else
      wp = 4'd2;
`endif
      apply(mk(0, 3'b001, 12'h001, 0, 0, 0, 3'b000, 0, 0, 2, wp), "dedge_idle");
      apply(mk(0, 3'b000, 12'h001, 0, 0, 1, 3'b001, 1, 0, 2, wp), "dedge_step");
      apply(mk(0, 3'b000, 12'h001, 0, 1, 0, 3'b000, 1, 1, 0, 1), "dedge_done");
      apply(mk(0, 3'b000, 12'h001, 0, 1, 0, 3'b000, 0, 0, 0, 1), "dedge_after");
    end

    // Reset at step 3 of a 6-step burst, then requester 2 is granted normally.
    apply(mk(0, 3'b100, 12'h600, 0, 0, 0, 3'b000, 0, 0, 0, 1), "rst_idle");
    apply(mk(0, 3'b000, 12'h600, 0, 0, 1, 3'b100, 1, 0, 0, 1), "rst_step1");
    apply(mk(0, 3'b000, 12'h600, 0, 0, 1, 3'b100, 1, 0, 0, 1), "rst_step2");
    apply(mk(1, 3'b000, 12'h600, 0, 0, 1, 3'b100, 1, 0, 0, 1), "rst_step3");
    apply(mk(0, 3'b100, 12'h100, 0, 0, 0, 3'b000, 0, 0, 0, 0), "rst_after");
    apply(mk(0, 3'b000, 12'h100, 0, 0, 1, 3'b100, 1, 0, 0, 0), "rst_regrant");
    apply(mk(0, 3'b000, 12'h100, 0, 0, 0, 3'b000, 1, 1, 2, 0), "rst_done");
    apply(mk(0, 3'b000, 12'h100, 0, 0, 0, 3'b000, 0, 0, 2, 0), "rst_idle2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
